// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and default width for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// One combinational iteration: shift-add multiply step or restoring-divide trial-subtract step.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     opnd,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}.
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // Divide: acc = {remainder, remaining dividend / growing quotient}; shifted remainder is WIDTH+1 bits.
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    fits   = (rem_sh >= {1'b0, opnd});
    diff   = acc[2*WIDTH-2:WIDTH-1] - opnd;
    if (is_div) begin
      if (fits) acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      else      acc_next = {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers; one iteration per cycle, result
// written to HI/LO WIDTH cycles after the start edge.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic              load, finish, move_ok;

  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   opnd, a_raw;
  logic               is_div, neg_res, neg_rem, div_zero;

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, hi_res, lo_res;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    finish    = 1'b0;
    move_ok   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          move_ok = 1'b1;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op && src_a[WIDTH-1];
    b_neg     = signed_op && src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  // Sign fix-up applied to the final iteration's output so HI/LO load on the completion edge.
  always_comb begin
    prod   = neg_res ? -acc_next : acc_next;
    quo    = acc_next[WIDTH-1:0];
    rem    = acc_next[2*WIDTH-1:WIDTH];
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (div_zero) begin
      hi_res = a_raw;
      lo_res = {WIDTH{1'b1}};
    end else if (is_div) begin
      hi_res = neg_rem ? -rem : rem;
      lo_res = neg_res ? -quo : quo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= finish;
      if (load)              cnt <= '0;
      else if (state == RUN) cnt <= cnt + 1'b1;
      if (finish) begin
        hi <= hi_res;
        lo <= lo_res;
      end else if (move_ok) begin
        if (mthi) hi <= wdata;
        if (mtlo) lo <= wdata;
      end
    end
  end

  // Datapath registers carry no architectural state, so they need no reset.
  always_ff @(posedge clk) begin
    if (load) begin
      is_div   <= op[1];
      opnd     <= op[1] ? b_mag : a_mag;
      acc      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= op[1] && (src_b == '0);
      a_raw    <= src_a;
    end else if (state == RUN) begin
      acc <= acc_next;
    end
  end

endmodule
